// File: rtl/fir_result_reader.sv
// Streams the FIR output region out of the shared sample memory over valid/ready,
// while accumulating a wrapping checksum and the peak sample magnitude.
module fir_result_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int CSUM_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] addr_a,
  output logic              we_a,
  output logic [DATA_W-1:0] data_in_a,
  input  logic [DATA_W-1:0] data_out_a,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [DATA_W-1:0] sample_data,
  output logic [ADDR_W-1:0] sample_index,
  output logic              busy,
  output logic              done,
  output logic [CSUM_W-1:0] checksum,
  output logic [DATA_W:0]   max_abs
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, FINISH} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic [DATA_W:0]   max_q, max_d;

  logic [ADDR_W-1:0] index_inc;
  logic [CSUM_W-1:0] sample_sext;
  logic [DATA_W:0]   sample_mag;

  assign index_inc   = index_q + ADDR_W'(1);
  assign sample_sext = {{(CSUM_W-DATA_W){data_q[DATA_W-1]}}, data_q};
  // One extra bit so that the most negative sample has a representable magnitude.
  assign sample_mag  = data_q[DATA_W-1] ? ((DATA_W+1)'(0) - {1'b1, data_q})
                                        : {1'b0, data_q};

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    base_d  = base_q;
    count_d = count_q;
    index_d = index_q;
    addr_d  = addr_q;
    data_d  = data_q;
    csum_d  = csum_q;
    max_d   = max_q;
    case (state_q)
      IDLE: begin
        // A start is captured first and launched on the following cycle, so the
        // memory address is always formed from the latched base register.
        if (req_q) begin
          req_d = 1'b0;
          if (count_q == '0) begin
            state_d = FINISH;
          end else begin
            state_d = ISSUE;
            addr_d  = base_q;
          end
        end else if (start) begin
          req_d   = 1'b1;
          base_d  = base_addr;
          count_d = count;
          index_d = '0;
          csum_d  = '0;
          max_d   = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        data_d  = data_out_a;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (sample_ready) begin
          csum_d  = csum_q + sample_sext;
          if (sample_mag > max_q) begin
            max_d = sample_mag;
          end
          index_d = index_inc;
          if (index_inc == count_q) begin
            state_d = FINISH;
          end else begin
            // The next address goes out with the transfer so ISSUE already presents it.
            addr_d  = base_q + index_inc;
            state_d = ISSUE;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      base_q  <= '0;
      count_q <= '0;
      index_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      csum_q  <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      base_q  <= base_d;
      count_q <= count_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
      max_q   <= max_d;
    end
  end

  assign addr_a       = addr_q;
  assign we_a         = 1'b0;
  assign data_in_a    = '0;
  assign sample_valid = (state_q == PRESENT);
  assign sample_data  = data_q;
  assign sample_index = index_q;
  assign busy         = (state_q == ISSUE) || (state_q == WAIT) || (state_q == PRESENT);
  assign done         = (state_q == FINISH);
  assign checksum     = csum_q;
  assign max_abs      = max_q;

endmodule

// File: tb/tb_fir_result_reader.sv
// Bench for fir_result_reader: table of readback runs plus hand-written
// zero-count, ignored-restart and mid-run reset sequences.
module tb_fir_result_reader;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] count;
  logic [AW-1:0] addr_a;
  logic          we_a;
  logic [DW-1:0] data_in_a;
  logic [DW-1:0] data_out_a;
  logic          sample_valid;
  logic          sample_ready;
  logic [DW-1:0] sample_data;
  logic [AW-1:0] sample_index;
  logic          busy;
  logic          done;
  logic [CW-1:0] checksum;
  logic [DW:0]   max_abs;

  always #5 clk = ~clk;

  fir_result_reader #(.ADDR_W(AW), .DATA_W(DW), .CSUM_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .addr_a(addr_a), .we_a(we_a), .data_in_a(data_in_a), .data_out_a(data_out_a),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .sample_index(sample_index), .busy(busy), .done(done), .checksum(checksum),
    .max_abs(max_abs)
  );

  // Shared sample memory, port A with a registered read.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) data_out_a <= mem[addr_a];

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] cnt;
    int            mode;   // 0: ready held high, 1: ready pattern 1-0-0-1
    logic [CW-1:0] csum;
    logic [DW:0]   maxa;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
  } exp_t;

  vec_t          vecs [5];
  exp_t          sb [$];
  int            checks = 0;
  int            failures = 0;
  logic [AW-1:0] last_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit repulse, input string tag);
    int            n;
    bit            got_done;
    int            done_at;
    int            stalls;
    int            first_valid;
    bit            stall_prev;
    bit            busy_ok;
    bit            we_ok;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_idx;
    exp_t          e;
    sb.delete();
    for (int i = 0; i < int'(v.cnt); i++) begin
      e.data = mem[(int'(v.base) + i) % 1024];
      e.idx  = AW'(i);
      sb.push_back(e);
    end
    n = 0; got_done = 0; done_at = -1; stalls = 0; first_valid = -1;
    stall_prev = 0; busy_ok = 1; we_ok = 1; hold_data = '0; hold_idx = '0;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; count = v.cnt;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom_range(0, 1023));
    count = AW'($urandom_range(0, 1023));
    while (!got_done && n < 300) begin
      sample_ready = (v.mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
      start = repulse && (n == 5);
      if (start) begin
        base_addr = '0;
        count = AW'(2);
      end
      @(negedge clk);
      if (n == 1) begin
        check({tag, " busy_after_T+1"}, busy, 1);
        check({tag, " addr_after_T+1"}, addr_a, v.base);
      end
      if (we_a !== 1'b0 || data_in_a !== '0) we_ok = 0;
      if (sample_valid && first_valid < 0) first_valid = n;
      if (stall_prev) begin
        check({tag, " hold_valid"}, sample_valid, 1);
        check({tag, " hold_data"}, sample_data, hold_data);
        check({tag, " hold_index"}, sample_index, hold_idx);
      end
      if (sample_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL %s extra_sample: got data %0h index %0d expected none", tag, sample_data, sample_index);
        end else begin
          check({tag, " sample_data"}, sample_data, sb[0].data);
          check({tag, " sample_index"}, sample_index, sb[0].idx);
          if (sample_ready) begin
            $display("%s transfer index=%0d data=%0d", tag, sample_index, $signed(sample_data));
            void'(sb.pop_front());
          end
        end
        stall_prev = !sample_ready;
        if (!sample_ready) stalls++;
        hold_data = sample_data;
        hold_idx  = sample_index;
      end else begin
        stall_prev = 0;
      end
      if (done) begin
        got_done = 1;
        done_at = n;
      end else begin
        if (n >= 1 && !busy) busy_ok = 0;
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    if (!got_done) begin
      checks++; failures++;
      $display("FAIL %s done_timeout: got no done in %0d cycles expected done", tag, n);
    end else begin
      check({tag, " done_cycle"}, done_at, 3 * int'(v.cnt) + 1 + stalls);
      check({tag, " busy_at_done"}, busy, 0);
      check({tag, " first_valid_cycle"}, first_valid, 3);
      check({tag, " samples_left"}, sb.size(), 0);
      check({tag, " checksum"}, checksum, v.csum);
      check({tag, " max_abs"}, max_abs, v.maxa);
      check({tag, " busy_during_run"}, busy_ok, 1);
      check({tag, " we_a_idle"}, we_ok, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, " done_single_pulse"}, done, 0);
      check({tag, " checksum_held"}, checksum, v.csum);
      $display("%s run base=%0d count=%0d done_at=%0d stalls=%0d checksum=%04h max_abs=%0d",
               tag, v.base, v.cnt, done_at, stalls, checksum, max_abs);
    end
    last_addr = AW'((int'(v.base) + int'(v.cnt) - 1) % 1024);
  endtask

  initial begin
    int n;
    bit found;
    bit got_done;
    vecs[0] = '{base: AW'(32),   cnt: AW'(4), mode: 0, csum: 16'h0001, maxa: 9'd128};
    vecs[1] = '{base: AW'(32),   cnt: AW'(4), mode: 1, csum: 16'h0001, maxa: 9'd128};
    vecs[2] = '{base: AW'(1022), cnt: AW'(3), mode: 0, csum: 16'h0006, maxa: 9'd3};
    vecs[3] = '{base: AW'(100),  cnt: AW'(5), mode: 1, csum: 16'h0026, maxa: 9'd50};
    vecs[4] = '{base: AW'(200),  cnt: AW'(1), mode: 0, csum: 16'hFF80, maxa: 9'd128};

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[32] = 8'd5;  mem[33] = 8'hFD; mem[34] = 8'h7F; mem[35] = 8'h80;
    mem[1022] = 8'd1; mem[1023] = 8'd2; mem[0] = 8'd3; mem[1] = 8'd9;
    mem[100] = 8'hFF; mem[101] = 8'h10; mem[102] = 8'hEC; mem[103] = 8'h32; mem[104] = 8'hF9;
    mem[200] = 8'h80;

    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; sample_ready = 1'b0;
    last_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset addr_a", addr_a, 0);
    check("reset sample_valid", sample_valid, 0);
    check("reset sample_data", sample_data, 0);
    check("reset sample_index", sample_index, 0);
    check("reset busy_done", {busy, done}, 0);
    check("reset checksum_max", {checksum, max_abs}, 0);
    check("reset we_data_in", {we_a, data_in_a}, 0);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Zero-length run: done two cycles in, no reads, stats cleared.
    @(negedge clk);
    start = 1'b1; base_addr = AW'(55); count = '0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; got_done = 0;
    while (!got_done && n < 20) begin
      @(negedge clk);
      check("cnt0 no_valid", sample_valid, 0);
      check("cnt0 no_busy", busy, 0);
      if (done) got_done = 1;
      else begin @(posedge clk); #1; n++; end
    end
    check("cnt0 done_cycle", got_done ? n : -1, 1);
    check("cnt0 addr_unchanged", addr_a, last_addr);
    check("cnt0 checksum", checksum, 0);
    check("cnt0 max_abs", max_abs, 0);
    $display("cnt0 run done_at=%0d addr_a=%0d checksum=%04h", n, addr_a, checksum);

    run_vec(vecs[0], 1'b1, "repulse");

    // Reset while sample 2 is being presented.
    @(negedge clk);
    start = 1'b1; base_addr = AW'(32); count = AW'(4); sample_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (sample_valid && sample_index == AW'(2)) found = 1;
      else begin @(posedge clk); #1; end
    end
    check("midrst reached_sample2", found, 1);
    rst = 1'b1; sample_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst addr_a", addr_a, 0);
    check("midrst valid_busy_done", {sample_valid, busy, done}, 0);
    check("midrst data_index", {sample_data, sample_index}, 0);
    check("midrst checksum_max", {checksum, max_abs}, 0);
    $display("midrst reset applied in PRESENT of sample 2");
    repeat (2) @(posedge clk);
    run_vec(vecs[0], 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
